flip_commit_scheduler: RTL and testbench

Batches single-spin flip requests from the annealing engine into a flip mask and commits each batch to the 1024-bit XOR state register (`xor_register_1024`) as one `en`/`D` pulse. It sits between the flip-acceptance stage and the state register, and owns all writes to that register: toggle commits and clears. Repeated flips of the same spin within a batch cancel in the mask, so the register sees only the net flip.

---
 rtl/annealer_pkg.sv | 15 +
 rtl/flip_commit_scheduler_if.sv | 25 ++
 rtl/flip_commit_scheduler.sv | 103 ++++++++++
 tb/tb_flip_commit_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/annealer_pkg.sv
// Constants and types shared by the annealer state register, the flip-acceptance
// stage and the flip commit scheduler.
package annealer_pkg;

  localparam int N_SPINS = 1024;
  // One spare code point above N_SPINS-1 so an out-of-range index can actually arrive.
  localparam int IDX_W   = $clog2(N_SPINS + 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMMIT  = 2'd1,
    CLEAR   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/flip_commit_scheduler_if.sv
// Requester-side bundle of the flip commit scheduler: flip stream plus batch control.
interface flip_commit_scheduler_if;
  import annealer_pkg::*;

  // A flip transfers on a rising edge where flip_valid && flip_ready; flip_idx is
  // only meaningful while flip_valid is high. batch_end and clr are one-cycle
  // requests, honoured only while flip_ready is high; commit_ack closes a batch.
  logic             flip_valid;
  logic [IDX_W-1:0] flip_idx;
  logic             flip_ready;
  logic             batch_end;
  logic             clr;
  logic             commit_ack;

  modport master (
    output flip_valid, flip_idx, batch_end, clr,
    input  flip_ready, commit_ack
  );

  modport slave (
    input  flip_valid, flip_idx, batch_end, clr,
    output flip_ready, commit_ack
  );

endinterface

// File: rtl/flip_commit_scheduler.sv
// Collects single-spin flips into an XOR mask and writes each batch to the
// 1024-bit state register as a single en/D pulse; also owns register clears.
module flip_commit_scheduler
  import annealer_pkg::*;
#(
  parameter int MAX_FLIPS = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  flip_commit_scheduler_if.slave req,
  output logic                   reg_en,
  output logic [N_SPINS-1:0]     reg_D,
  output logic                   reg_clr,
  output logic [IDX_W:0]         flip_count,
  output logic                   idx_err,
  output sched_state_t           state
);

  localparam int               SEL_W   = $clog2(N_SPINS);
  localparam logic [IDX_W:0]   MAX_CNT = (IDX_W + 1)'(MAX_FLIPS);

  sched_state_t       state_d;
  logic [N_SPINS-1:0] mask, mask_d, mask_flip;
  logic [IDX_W:0]     count_d, count_flip;
  logic               idx_err_d;
  logic               empty_ack, empty_ack_d;
  logic               accept, in_range;

  assign accept   = req.flip_valid && (state == COLLECT);
  assign in_range = req.flip_idx < IDX_W'(N_SPINS);

  // Post-accept view of the open batch: decoder-and-XOR toggle plus count.
  always_comb begin
    mask_flip  = mask;
    count_flip = flip_count;
    if (accept && in_range) begin
      mask_flip[req.flip_idx[SEL_W-1:0]] = ~mask[req.flip_idx[SEL_W-1:0]];
      count_flip = flip_count + (IDX_W + 1)'(1);
    end
  end

  always_comb begin
    state_d     = state;
    mask_d      = mask;
    count_d     = flip_count;
    empty_ack_d = 1'b0;
    idx_err_d   = idx_err | (accept & ~in_range);
    case (state)
      COLLECT: begin
        if (req.clr) begin
          // The flip accepted alongside clr is dropped; CLEAR wipes the batch.
          state_d = CLEAR;
        end else begin
          mask_d  = mask_flip;
          count_d = count_flip;
          if (req.batch_end || (count_flip == MAX_CNT)) begin
            if (|mask_flip) begin
              state_d = COMMIT;
            end else begin
              // Net-zero batch: acknowledge without touching the register.
              empty_ack_d = 1'b1;
              count_d     = '0;
            end
          end
        end
      end
      COMMIT, CLEAR: begin
        state_d = COLLECT;
        mask_d  = '0;
        count_d = '0;
      end
      default: begin
        state_d = COLLECT;
        mask_d  = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      mask       <= '0;
      flip_count <= '0;
      idx_err    <= 1'b0;
      empty_ack  <= 1'b0;
    end else begin
      state      <= state_d;
      mask       <= mask_d;
      flip_count <= count_d;
      idx_err    <= idx_err_d;
      empty_ack  <= empty_ack_d;
    end
  end

  // Outputs decode straight from flops so reset drops reg_en asynchronously.
  assign reg_en         = (state == COMMIT);
  assign reg_clr        = (state == CLEAR);
  assign reg_D          = mask;
  assign req.flip_ready = (state == COLLECT);
  assign req.commit_ack = reg_en | empty_ack;

endmodule

// File: tb/tb_flip_commit_scheduler.sv
// Self-checking bench for flip_commit_scheduler: table of per-cycle vectors,
// a scoreboard of expected register events, and a few hand-written sequences.
`timescale 1ns/1ps
module tb_flip_commit_scheduler;
  import annealer_pkg::*;

  localparam int         MAXF     = 4;
  localparam int         EW       = N_SPINS + 2;
  localparam logic [1:0] K_COMMIT = 2'd1;
  localparam logic [1:0] K_EMPTY  = 2'd2;
  localparam logic [1:0] K_CLR    = 2'd3;

  typedef struct {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             be;
    logic             cl;
    logic [IDX_W:0]   cnt;
    logic             rdy;
    logic             err;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flip_commit_scheduler_if bus();
  logic               reg_en;
  logic [N_SPINS-1:0] reg_D;
  logic               reg_clr;
  logic [IDX_W:0]     flip_count;
  logic               idx_err;
  sched_state_t       state;

  flip_commit_scheduler #(.MAX_FLIPS(MAXF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (bus),
    .reg_en     (reg_en),
    .reg_D      (reg_D),
    .reg_clr    (reg_clr),
    .flip_count (flip_count),
    .idx_err    (idx_err),
    .state      (state)
  );

  // Stand-in for the XOR state register driven by the scheduler.
  logic [N_SPINS-1:0] q_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       q_reg <= '0;
    else if (reg_clr) q_reg <= '0;
    else if (reg_en)  q_reg <= q_reg ^ reg_D;
  end

  // ---------------- scoreboard state ----------------
  int                 checks   = 0;
  int                 failures = 0;
  logic [EW-1:0]      exp_q[$];
  logic [EW-1:0]      mon_e;
  logic [N_SPINS-1:0] m_mask = '0;
  logic [N_SPINS-1:0] m_q    = '0;
  int                 m_count = 0;
  logic               m_busy  = 1'b0;
  vec_t               tbl[$];

  function automatic int first_diff(input logic [N_SPINS-1:0] d);
    for (int i = 0; i < N_SPINS; i++) if (d[i] !== 1'b0) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_mask(input string name, input logic [N_SPINS-1:0] act,
                            input logic [N_SPINS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d bits set expected %0d, first differing bit %0d",
               name, $countones(act), $countones(exp), first_diff(act ^ exp));
    end
  endtask

  // Predicts what the coming edge does and queues any register event it causes.
  task automatic model_edge(input logic v, input logic [IDX_W-1:0] idx,
                            input logic be, input logic cl);
    logic acc;
    acc = v && !m_busy;
    if (m_busy) begin
      m_busy = 1'b0;
    end else if (cl) begin
      exp_q.push_back({K_CLR, {N_SPINS{1'b0}}});
      m_mask = '0; m_count = 0; m_q = '0; m_busy = 1'b1;
    end else begin
      if (acc && (int'(idx) < N_SPINS)) begin
        m_mask  = m_mask ^ (N_SPINS'(1) << idx);
        m_count = m_count + 1;
      end
      if (be || (m_count == MAXF)) begin
        if (m_mask != '0) begin
          exp_q.push_back({K_COMMIT, m_mask});
          m_q    = m_q ^ m_mask;
          m_busy = 1'b1;
        end else begin
          exp_q.push_back({K_EMPTY, {N_SPINS{1'b0}}});
        end
        m_mask = '0; m_count = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input vec_t v, input string tag);
    bus.flip_valid = v.valid;
    bus.flip_idx   = v.idx;
    bus.batch_end  = v.be;
    bus.clr        = v.cl;
    model_edge(v.valid, v.idx, v.be, v.cl);
    @(posedge clk); #1;
    check({tag, "_flip_count"}, 32'(flip_count), 32'(v.cnt));
    check({tag, "_flip_ready"}, 32'(bus.flip_ready), 32'(v.rdy));
    check({tag, "_idx_err"}, 32'(idx_err), 32'(v.err));
    if (!m_busy) begin
      check_mask({tag, "_mask"}, reg_D, m_mask);
      check_mask({tag, "_q"}, q_reg, m_q);
    end
  endtask

  function automatic vec_t mk(input logic v, input int idx, input logic be, input logic cl,
                              input int cnt, input logic rdy, input logic err);
    vec_t r;
    r.valid = v; r.idx = IDX_W'(idx); r.be = be; r.cl = cl;
    r.cnt = (IDX_W + 1)'(cnt); r.rdy = rdy; r.err = err;
    return r;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && (reg_en || reg_clr || bus.commit_ack)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: reg_en=%0d reg_clr=%0d commit_ack=%0d, none expected",
                 reg_en, reg_clr, bus.commit_ack);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_reg_en", 32'(reg_en), 32'(mon_e[EW-1:EW-2] == K_COMMIT));
        check("event_reg_clr", 32'(reg_clr), 32'(mon_e[EW-1:EW-2] == K_CLR));
        check("event_commit_ack", 32'(bus.commit_ack), 32'(mon_e[EW-1:EW-2] != K_CLR));
        if (mon_e[EW-1:EW-2] == K_COMMIT) check_mask("commit_reg_D", reg_D, mon_e[N_SPINS-1:0]);
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    // Rows: valid, idx, batch_end, clr -> flip_count, flip_ready, idx_err after the edge.
    tbl.push_back(mk(1,    3, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1,    7, 0, 0, 2, 1, 0));
    tbl.push_back(mk(1, 1023, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0,    0, 1, 0, 3, 0, 0));
    tbl.push_back(mk(0,    0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1,    5, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1,    5, 0, 0, 2, 1, 0));
    tbl.push_back(mk(1,    9, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0,    0, 1, 0, 3, 0, 0));
    tbl.push_back(mk(0,    0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1,    5, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1,    5, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0,    0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0,    0, 0, 0, 0, 1, 0));
    // Continuous valid on 0..7 with auto-commit at 4; index 4 held through the bubble.
    tbl.push_back(mk(1,    0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1,    1, 0, 0, 2, 1, 0));
    tbl.push_back(mk(1,    2, 0, 0, 3, 1, 0));
    tbl.push_back(mk(1,    3, 0, 0, 4, 0, 0));
    tbl.push_back(mk(1,    4, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1,    4, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1,    5, 0, 0, 2, 1, 0));
    tbl.push_back(mk(1,    6, 0, 0, 3, 1, 0));
    tbl.push_back(mk(1,    7, 0, 0, 4, 0, 0));
    tbl.push_back(mk(0,    0, 0, 0, 0, 1, 0));
    // Flip alongside batch_end joins the batch; flip alongside clr is dropped.
    tbl.push_back(mk(1,   12, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0,    0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1,   20, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1,   13, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0,    0, 0, 0, 0, 1, 0));
    // Out-of-range index: sticky error, no count or mask change.
    tbl.push_back(mk(1, 1024, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1,    2, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0,    0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0,    0, 0, 0, 0, 1, 1));

    rst_n = 1'b0;
    bus.flip_valid = 1'b0;
    bus.flip_idx   = '0;
    bus.batch_end  = 1'b0;
    bus.clr        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'(COLLECT));
    check("reset_flip_ready", 32'(bus.flip_ready), 32'd1);
    check("reset_reg_en", 32'(reg_en), 32'd0);
    check("reset_reg_clr", 32'(reg_clr), 32'd0);
    check("reset_commit_ack", 32'(bus.commit_ack), 32'd0);
    check("reset_flip_count", 32'(flip_count), 32'd0);
    check("reset_idx_err", 32'(idx_err), 32'd0);
    check_mask("reset_mask", reg_D, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

    // Reset asserted during the COMMIT cycle discards the batch.
    step(mk(1, 40, 0, 0, 1, 1, 1), "rst_a");
    step(mk(1, 41, 0, 0, 2, 1, 1), "rst_b");
    bus.flip_valid = 1'b0;
    bus.batch_end  = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_reg_en", 32'(reg_en), 32'd1);
    check_mask("pre_reset_reg_D", reg_D, (N_SPINS'(1) << 40) | (N_SPINS'(1) << 41));
    rst_n = 1'b0;
    #1;
    check("async_reset_reg_en", 32'(reg_en), 32'd0);
    check("async_reset_commit_ack", 32'(bus.commit_ack), 32'd0);
    check("async_reset_flip_count", 32'(flip_count), 32'd0);
    check("async_reset_idx_err", 32'(idx_err), 32'd0);
    check_mask("async_reset_mask", reg_D, '0);
    bus.batch_end = 1'b0;
    m_mask = '0; m_q = '0; m_count = 0; m_busy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_state", 32'(state), 32'(COLLECT));
    check("post_reset_flip_ready", 32'(bus.flip_ready), 32'd1);
    step(mk(1, 6, 1, 0, 1, 0, 0), "post_a");
    step(mk(0, 0, 0, 0, 0, 1, 0), "post_b");

    repeat (2) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
